// File: rtl/fifo_arb_pkg.sv
// Shared types, default widths and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_BURST_LEN = 4;
    localparam int DEF_STALL_MAX = 16;
    localparam int DEF_CNT_W     = 4;

    // Bits needed to index n items (at least 1).
    function automatic int idx_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Bits needed to hold the values 0..max_val (at least 1).
    function automatic int cnt_width(input int max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    localparam int OWN_W = idx_width(DEF_N_REQ);

endpackage

// File: rtl/fifo_wr_arbiter_rr_picker.sv
// Combinational round-robin picker: first set request scanning upward from last_owner+1.
module rr_picker
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int OWN_W = idx_width(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [OWN_W-1:0] last_owner,
    output logic [OWN_W-1:0] pick_idx,
    output logic             pick_vld
);

    // Scan from the farthest candidate down so the nearest one after last_owner wins.
    always_comb begin
        int idx;
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        idx      = 0;
        pick_idx = '0;
        pick_vld = 1'b0;
        for (int k = N_REQ; k >= 1; k--) begin
            idx = (int'(last_owner) + k) % N_REQ;
            if (req[OWN_W'(idx)]) begin
                pick_idx = OWN_W'(idx);
                pick_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-granted round-robin arbiter sharing one sync FIFO write port among N_REQ producers,
// with a watchdog that revokes a grant stuck behind a full FIFO.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = DEF_DW,
    parameter int BURST_LEN = DEF_BURST_LEN,
    parameter int STALL_MAX = DEF_STALL_MAX,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N_REQ-1:0]    req,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    ack,
    output logic [N_REQ-1:0]    grant,
    output logic                fifo_wr,
    output logic [DW-1:0]       fifo_din,
    input  logic                fifo_full,
    input  logic [CNT_W-1:0]    fifo_cnt,
    output logic                stall_err
);

    localparam int OWN_W   = idx_width(N_REQ);
    localparam int BEAT_W  = cnt_width(BURST_LEN);
    localparam int STALL_W = cnt_width(STALL_MAX);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

    arb_state_t         r_state;
    arb_state_t         w_next_state;
    logic [OWN_W-1:0]   r_owner;
    logic [OWN_W-1:0]   r_last_owner;
    logic [N_REQ-1:0]   r_grant;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic               r_stall_err;

    logic [OWN_W-1:0]   w_pick_idx;
    logic               w_pick_vld;
    logic               w_owner_req;
    logic               w_wr;
    logic               w_last_beat;
    logic               w_drop;
    logic               w_stall_fire;
    logic               w_exit;
    logic [DW-1:0]      w_data [N_REQ];

    // Occupancy is status only; it never steers the arbiter.
    logic               w_unused_cnt;
    assign w_unused_cnt = ^fifo_cnt;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_data
        assign w_data[gi] = req_data[gi*DW +: DW];
    end

    rr_picker #(
        .N_REQ (N_REQ),
        .OWN_W (OWN_W)
    ) u_picker (
        .req        (req),
        .last_owner (r_last_owner),
        .pick_idx   (w_pick_idx),
        .pick_vld   (w_pick_vld)
    );

    assign w_owner_req  = req[r_owner];
    assign w_wr         = (r_state == BURST) && w_owner_req && !fifo_full;
    assign w_last_beat  = w_wr && (r_beat_cnt == BEAT_W'(BURST_LEN - 1));
    assign w_drop       = (r_state == BURST) && !w_owner_req;
    assign w_stall_fire = (r_state == BURST) && w_owner_req && fifo_full
                          && (r_stall_cnt == STALL_W'(STALL_MAX - 1));
    assign w_exit       = w_last_beat || w_drop || w_stall_fire;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE:    if (w_pick_vld) w_next_state = BURST;
            BURST:   if (w_exit)     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        ack      = '0;
        fifo_wr  = w_wr;
        fifo_din = w_wr ? w_data[r_owner] : '0;
        ack[r_owner] = w_wr;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_owner      <= '0;
            r_last_owner <= OWN_W'(N_REQ - 1);
            r_grant      <= '0;
            r_beat_cnt   <= '0;
            r_stall_cnt  <= '0;
            r_stall_err  <= 1'b0;
        end else begin
            r_stall_err <= w_stall_fire;
            case (r_state)
                IDLE: begin
                    if (w_pick_vld) begin
                        r_owner     <= w_pick_idx;
                        r_grant     <= ONE_HOT0 << w_pick_idx;
                        r_beat_cnt  <= '0;
                        r_stall_cnt <= '0;
                    end
                end
                BURST: begin
                    if (w_exit) begin
                        r_last_owner <= r_owner;
                        r_grant      <= '0;
                    end else if (w_wr) begin
                        r_beat_cnt  <= r_beat_cnt + 1'b1;
                        r_stall_cnt <= '0;
                    end else if (w_owner_req && fifo_full) begin
                        r_stall_cnt <= r_stall_cnt + 1'b1;
                    end
                end
                default: r_grant <= '0;
            endcase
        end
    end

    assign grant     = r_grant;
    assign stall_err = r_stall_err;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: producer models feed the DUT, a scoreboard monitor checks every write.
module tb_fifo_wr_arbiter;
    import fifo_arb_pkg::*;

    localparam int N  = 4;
    localparam int DW = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    ack;
    logic [N-1:0]    grant;
    logic            fifo_wr;
    logic [DW-1:0]   fifo_din;
    logic            fifo_full;
    logic [CW-1:0]   fifo_cnt;
    logic            stall_err;

    fifo_wr_arbiter #(
        .N_REQ(N), .DW(DW), .BURST_LEN(4), .STALL_MAX(16), .CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .req_data  (req_data),
        .ack       (ack),
        .grant     (grant),
        .fifo_wr   (fifo_wr),
        .fifo_din  (fifo_din),
        .fifo_full (fifo_full),
        .fifo_cnt  (fifo_cnt),
        .stall_err (stall_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          owner;
        logic [7:0]  data;
    } beat_t;

    beat_t       exp_q[$];
    int          checks = 0;
    int          errors = 0;

    int          left      [N];
    logic [7:0]  dat       [N];
    int          pend_n    [N];
    logic [7:0]  pend_base [N];
    logic [N-1:0] xfer;
    logic        full_next;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push(input int owner, input logic [7:0] data);
        beat_t b;
        b.owner = owner;
        b.data  = data;
        exp_q.push_back(b);
    endtask

    task automatic drive_inputs();
        for (int i = 0; i < N; i++) begin
            req[i]               = (left[i] > 0);
            req_data[i*DW +: DW] = dat[i];
        end
        fifo_full = full_next;
        fifo_cnt  = full_next ? 4'd8 : 4'd0;
    endtask

    // One clock: apply producer progress and queued stimulus after the edge, sample transfers at the negedge.
    task automatic step();
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) begin
            if (xfer[i]) begin
                dat[i]  = dat[i] + 8'd1;
                left[i] = left[i] - 1;
            end
            if (pend_n[i] > 0) begin
                left[i]   = pend_n[i];
                dat[i]    = pend_base[i];
                pend_n[i] = 0;
            end
        end
        drive_inputs();
        @(negedge clk);
        xfer = req & ack;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || req != '0) && n < 100) begin
            step();
            n++;
        end
        repeat (2) step();
        check({name, "_queue"}, exp_q.size(), 0);
        check({name, "_req"}, req, 0);
    endtask

    // Scoreboard monitor.
    initial begin
        beat_t e;
        forever begin
            @(negedge clk);
            if (!reset) begin
                if (fifo_wr) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL spurious_write: got din=%0h ack=%b, expected no write (t=%0t)",
                                 fifo_din, ack, $time);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_data", fifo_din, e.data);
                        check("wr_ack", ack, 1 << e.owner);
                        check("wr_while_full", fifo_full, 0);
                    end
                end else begin
                    check("ack_without_wr", ack, 0);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded its time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int ord [4];
        ord = '{3, 0, 1, 2};
        for (int i = 0; i < N; i++) begin
            left[i] = 0; dat[i] = '0; pend_n[i] = 0; pend_base[i] = '0;
        end
        xfer      = '0;
        full_next = 1'b0;
        reset     = 1'b1;
        drive_inputs();
        repeat (2) @(negedge clk);
        check("rst_grant", grant, 0);
        check("rst_ack", ack, 0);
        check("rst_fifo_wr", fifo_wr, 0);
        check("rst_fifo_din", fifo_din, 0);
        check("rst_stall_err", stall_err, 0);
        reset = 1'b0;

        // Single requester 2, six beats: 4-beat burst, one idle cycle, re-grant for the last 2.
        pend_n[2] = 6; pend_base[2] = 8'h20;
        for (int j = 0; j < 6; j++) push(2, 8'h20 + 8'(j));
        step(); check("t1_arb_cycle", grant, 4'b0000);
        step(); check("t1_grant", grant, 4'b0100);
        repeat (3) step();
        step(); check("t1_idle_between", grant, 4'b0000);
        step(); check("t1_regrant", grant, 4'b0100);
        drain("t1");

        // All four requesting, FIFO never full; last owner was 2 so rotation starts at 3.
        for (int i = 0; i < N; i++) begin
            pend_n[i] = 8; pend_base[i] = 8'(i * 16);
        end
        for (int r = 0; r < 2; r++)
            for (int o = 0; o < 4; o++)
                for (int j = 0; j < 4; j++)
                    push(ord[o], 8'(ord[o] * 16 + r * 4 + j));
        drain("t2");

        // Owner 1 drops after 2 beats; requester 2 is next.
        pend_n[1] = 2; pend_base[1] = 8'h40;
        pend_n[2] = 2; pend_base[2] = 8'h50;
        push(1, 8'h40); push(1, 8'h41); push(2, 8'h50); push(2, 8'h51);
        step();
        step(); check("t3_grant1", grant, 4'b0010);
        step();
        step(); check("t3_drop_no_write", fifo_wr, 0);
        step(); check("t3_idle_after_drop", grant, 4'b0000);
        step(); check("t3_next_owner", grant, 4'b0100);
        drain("t3");

        // FIFO held full: watchdog revokes owner 0 after 16 stall cycles, grant moves to 1.
        full_next = 1'b1;
        pend_n[0] = 1; pend_base[0] = 8'h60;
        pend_n[1] = 1; pend_base[1] = 8'h70;
        push(1, 8'h70); push(0, 8'h60);
        step();
        for (int k = 0; k < 16; k++) begin
            step();
            check("t4_stall_grant", grant, 4'b0001);
            check("t4_no_write", fifo_wr, 0);
            check("t4_no_err_yet", stall_err, 0);
        end
        step();
        check("t4_stall_err", stall_err, 1);
        check("t4_revoked", grant, 4'b0000);
        step();
        check("t4_next_grant", grant, 4'b0010);
        check("t4_err_pulse", stall_err, 0);
        full_next = 1'b0;
        drain("t4");

        // Full falls after 5 stall cycles: write that cycle, stall count restarts.
        full_next = 1'b1;
        pend_n[3] = 2; pend_base[3] = 8'h80;
        push(3, 8'h80); push(3, 8'h81);
        step();
        step(); check("t5_grant", grant, 4'b1000);
        repeat (4) begin
            step(); check("t5_stalled", fifo_wr, 0);
        end
        full_next = 1'b0;
        step(); check("t5_write_on_drain", fifo_wr, 1);
        full_next = 1'b1;
        for (int k = 0; k < 15; k++) begin
            step();
            check("t5_no_err", stall_err, 0);
            check("t5_hold_grant", grant, 4'b1000);
        end
        full_next = 1'b0;
        step(); check("t5_second_write", fifo_wr, 1);
        drain("t5");

        // Reset mid-burst with the third beat in flight; it is re-presented after reset.
        pend_n[1] = 8; pend_base[1] = 8'hA0;
        push(1, 8'hA0); push(1, 8'hA1); push(1, 8'hA2);
        repeat (4) step();
        #1;
        reset = 1'b1;
        xfer  = '0;
        #1;
        check("t6_async_grant", grant, 0);
        check("t6_async_ack", ack, 0);
        check("t6_async_wr", fifo_wr, 0);
        check("t6_async_din", fifo_din, 0);
        pend_n[0] = 1; pend_base[0] = 8'hB0;
        repeat (2) begin
            step();
            check("t6_in_reset_grant", grant, 0);
            check("t6_in_reset_wr", fifo_wr, 0);
        end
        reset = 1'b0;
        push(0, 8'hB0);
        for (int j = 2; j < 8; j++) push(1, 8'hA0 + 8'(j));
        step(); check("t6_first_grant", grant, 4'b0001);
        drain("t6");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
